// File: rtl/axi_wr_arbiter.sv
// Two-master round-robin AXI write arbiter: one grant per transaction, held until B completes.
// The master number is prefixed onto the downstream ID; WLAST_S is generated from the granted AWLEN.
module axi_wr_arbiter #(
  parameter int unsigned ID_BITS   = 4,
  parameter int unsigned ADDR_BITS = 32,
  parameter int unsigned DATA_BITS = 32,
  parameter int unsigned LEN_BITS  = 4
) (
  input  logic                   ACLK,
  input  logic                   ARESETn,
  // Master 0
  input  logic [ID_BITS-1:0]     AWID_M0,
  input  logic [ADDR_BITS-1:0]   AWADDR_M0,
  input  logic [LEN_BITS-1:0]    AWLEN_M0,
  input  logic [2:0]             AWSIZE_M0,
  input  logic [1:0]             AWBURST_M0,
  input  logic                   AWVALID_M0,
  output logic                   AWREADY_M0,
  input  logic [DATA_BITS-1:0]   WDATA_M0,
  input  logic [DATA_BITS/8-1:0] WSTRB_M0,
  input  logic                   WLAST_M0,
  input  logic                   WVALID_M0,
  output logic                   WREADY_M0,
  output logic [ID_BITS-1:0]     BID_M0,
  output logic [1:0]             BRESP_M0,
  output logic                   BVALID_M0,
  input  logic                   BREADY_M0,
  // Master 1
  input  logic [ID_BITS-1:0]     AWID_M1,
  input  logic [ADDR_BITS-1:0]   AWADDR_M1,
  input  logic [LEN_BITS-1:0]    AWLEN_M1,
  input  logic [2:0]             AWSIZE_M1,
  input  logic [1:0]             AWBURST_M1,
  input  logic                   AWVALID_M1,
  output logic                   AWREADY_M1,
  input  logic [DATA_BITS-1:0]   WDATA_M1,
  input  logic [DATA_BITS/8-1:0] WSTRB_M1,
  input  logic                   WLAST_M1,
  input  logic                   WVALID_M1,
  output logic                   WREADY_M1,
  output logic [ID_BITS-1:0]     BID_M1,
  output logic [1:0]             BRESP_M1,
  output logic                   BVALID_M1,
  input  logic                   BREADY_M1,
  // Downstream slave port
  output logic [ID_BITS+3:0]     AWID_S,
  output logic [ADDR_BITS-1:0]   AWADDR_S,
  output logic [LEN_BITS-1:0]    AWLEN_S,
  output logic [2:0]             AWSIZE_S,
  output logic [1:0]             AWBURST_S,
  output logic                   AWVALID_S,
  input  logic                   AWREADY_S,
  output logic [DATA_BITS-1:0]   WDATA_S,
  output logic [DATA_BITS/8-1:0] WSTRB_S,
  output logic                   WLAST_S,
  output logic                   WVALID_S,
  input  logic                   WREADY_S,
  input  logic [ID_BITS+3:0]     BID_S,
  input  logic [1:0]             BRESP_S,
  input  logic                   BVALID_S,
  output logic                   BREADY_S,
  output logic                   wlast_err
);

  typedef enum logic [1:0] {StIdle, StAddr, StData, StResp} state_e;

  state_e                state_q, state_d;
  logic                  grant_q, grant_d;
  logic                  last_grant_q, last_grant_d;
  logic [LEN_BITS-1:0]   len_q, len_d;
  logic [LEN_BITS-1:0]   beat_cnt_q, beat_cnt_d;

  // Granted master's request-side signals
  logic                  awvalid_g, wvalid_g, wlast_g, bready_g;
  logic [ID_BITS-1:0]    awid_g;
  logic [ADDR_BITS-1:0]  awaddr_g;
  logic [LEN_BITS-1:0]   awlen_g;
  logic [2:0]            awsize_g;
  logic [1:0]            awburst_g;
  logic [DATA_BITS-1:0]  wdata_g;
  logic [DATA_BITS/8-1:0] wstrb_g;

  logic                  idle_sel;
  logic                  wlast_gen;
  logic                  w_hs, b_hs, aw_hs;

  assign awvalid_g = grant_q ? AWVALID_M1 : AWVALID_M0;
  assign awid_g    = grant_q ? AWID_M1    : AWID_M0;
  assign awaddr_g  = grant_q ? AWADDR_M1  : AWADDR_M0;
  assign awlen_g   = grant_q ? AWLEN_M1   : AWLEN_M0;
  assign awsize_g  = grant_q ? AWSIZE_M1  : AWSIZE_M0;
  assign awburst_g = grant_q ? AWBURST_M1 : AWBURST_M0;
  assign wvalid_g  = grant_q ? WVALID_M1  : WVALID_M0;
  assign wdata_g   = grant_q ? WDATA_M1   : WDATA_M0;
  assign wstrb_g   = grant_q ? WSTRB_M1   : WSTRB_M0;
  assign wlast_g   = grant_q ? WLAST_M1   : WLAST_M0;
  assign bready_g  = grant_q ? BREADY_M1  : BREADY_M0;

  // On contention the master that did not win last time goes next
  assign idle_sel  = (AWVALID_M0 && AWVALID_M1) ? ~last_grant_q : AWVALID_M1;
  assign wlast_gen = (beat_cnt_q == len_q);
  assign aw_hs     = (state_q == StAddr) && awvalid_g && AWREADY_S;
  assign w_hs      = (state_q == StData) && wvalid_g && WREADY_S;
  assign b_hs      = (state_q == StResp) && BVALID_S && bready_g;

  // Next-state: grant, burst length capture and beat counting
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    len_d        = len_q;
    beat_cnt_d   = beat_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (AWVALID_M0 || AWVALID_M1) begin
          grant_d = idle_sel;
          len_d   = idle_sel ? AWLEN_M1 : AWLEN_M0;
          state_d = StAddr;
        end
      end
      StAddr: begin
        if (aw_hs) begin
          beat_cnt_d = '0;
          state_d    = StData;
        end
      end
      StData: begin
        if (w_hs) begin
          beat_cnt_d = beat_cnt_q + LEN_BITS'(1);
          if (wlast_gen) state_d = StResp;
        end
      end
      StResp: begin
        if (b_hs) begin
          last_grant_d = grant_q;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; last_grant resets to 1 so M0 wins the first contention
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q      <= StIdle;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      len_q        <= '0;
      beat_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      len_q        <= len_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

  // Output routing: each channel is forwarded only in its owning state, zeroed otherwise
  always_comb begin
    AWVALID_S  = 1'b0;
    AWID_S     = '0;
    AWADDR_S   = '0;
    AWLEN_S    = '0;
    AWSIZE_S   = '0;
    AWBURST_S  = '0;
    AWREADY_M0 = 1'b0;
    AWREADY_M1 = 1'b0;
    WVALID_S   = 1'b0;
    WDATA_S    = '0;
    WSTRB_S    = '0;
    WLAST_S    = 1'b0;
    WREADY_M0  = 1'b0;
    WREADY_M1  = 1'b0;
    BVALID_M0  = 1'b0;
    BVALID_M1  = 1'b0;
    BID_M0     = '0;
    BID_M1     = '0;
    BRESP_M0   = '0;
    BRESP_M1   = '0;
    BREADY_S   = 1'b0;
    wlast_err  = 1'b0;
    unique case (state_q)
      StAddr: begin
        AWVALID_S = awvalid_g;
        if (awvalid_g) begin
          AWID_S    = {4'(grant_q), awid_g};
          AWADDR_S  = awaddr_g;
          AWLEN_S   = awlen_g;
          AWSIZE_S  = awsize_g;
          AWBURST_S = awburst_g;
        end
        AWREADY_M0 = ~grant_q & AWREADY_S;
        AWREADY_M1 = grant_q & AWREADY_S;
      end
      StData: begin
        WVALID_S = wvalid_g;
        if (wvalid_g) begin
          WDATA_S = wdata_g;
          WSTRB_S = wstrb_g;
          WLAST_S = wlast_gen;
        end
        WREADY_M0 = ~grant_q & WREADY_S;
        WREADY_M1 = grant_q & WREADY_S;
        // Master WLAST is only checked, never forwarded
        wlast_err = w_hs && (wlast_g != wlast_gen);
      end
      StResp: begin
        BVALID_M0 = ~grant_q & BVALID_S;
        BVALID_M1 = grant_q & BVALID_S;
        if (BVALID_S) begin
          if (grant_q) begin
            BID_M1   = BID_S[ID_BITS-1:0];
            BRESP_M1 = BRESP_S;
          end else begin
            BID_M0   = BID_S[ID_BITS-1:0];
            BRESP_M0 = BRESP_S;
          end
        end
        BREADY_S = bready_g;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Directed plus randomized bench for axi_wr_arbiter with a transaction-level reference model.
module tb_axi_wr_arbiter;
  localparam int IDB = 4;
  localparam int AB  = 32;
  localparam int DB  = 32;
  localparam int LB  = 4;

  logic ACLK, ARESETn;
  logic [IDB-1:0] AWID_M0, AWID_M1, BID_M0, BID_M1;
  logic [AB-1:0]  AWADDR_M0, AWADDR_M1, AWADDR_S;
  logic [LB-1:0]  AWLEN_M0, AWLEN_M1, AWLEN_S;
  logic [2:0]     AWSIZE_M0, AWSIZE_M1, AWSIZE_S;
  logic [1:0]     AWBURST_M0, AWBURST_M1, AWBURST_S;
  logic           AWVALID_M0, AWVALID_M1, AWREADY_M0, AWREADY_M1;
  logic [DB-1:0]  WDATA_M0, WDATA_M1, WDATA_S;
  logic [DB/8-1:0] WSTRB_M0, WSTRB_M1, WSTRB_S;
  logic           WLAST_M0, WLAST_M1, WVALID_M0, WVALID_M1, WREADY_M0, WREADY_M1;
  logic [1:0]     BRESP_M0, BRESP_M1, BRESP_S;
  logic           BVALID_M0, BVALID_M1, BREADY_M0, BREADY_M1;
  logic [IDB+3:0] AWID_S, BID_S;
  logic           AWVALID_S, AWREADY_S, WLAST_S, WVALID_S, WREADY_S;
  logic           BVALID_S, BREADY_S, wlast_err;

  axi_wr_arbiter #(.ID_BITS(IDB), .ADDR_BITS(AB), .DATA_BITS(DB), .LEN_BITS(LB)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWID_M0(AWID_M0), .AWADDR_M0(AWADDR_M0), .AWLEN_M0(AWLEN_M0), .AWSIZE_M0(AWSIZE_M0),
    .AWBURST_M0(AWBURST_M0), .AWVALID_M0(AWVALID_M0), .AWREADY_M0(AWREADY_M0),
    .WDATA_M0(WDATA_M0), .WSTRB_M0(WSTRB_M0), .WLAST_M0(WLAST_M0), .WVALID_M0(WVALID_M0),
    .WREADY_M0(WREADY_M0), .BID_M0(BID_M0), .BRESP_M0(BRESP_M0), .BVALID_M0(BVALID_M0),
    .BREADY_M0(BREADY_M0),
    .AWID_M1(AWID_M1), .AWADDR_M1(AWADDR_M1), .AWLEN_M1(AWLEN_M1), .AWSIZE_M1(AWSIZE_M1),
    .AWBURST_M1(AWBURST_M1), .AWVALID_M1(AWVALID_M1), .AWREADY_M1(AWREADY_M1),
    .WDATA_M1(WDATA_M1), .WSTRB_M1(WSTRB_M1), .WLAST_M1(WLAST_M1), .WVALID_M1(WVALID_M1),
    .WREADY_M1(WREADY_M1), .BID_M1(BID_M1), .BRESP_M1(BRESP_M1), .BVALID_M1(BVALID_M1),
    .BREADY_M1(BREADY_M1),
    .AWID_S(AWID_S), .AWADDR_S(AWADDR_S), .AWLEN_S(AWLEN_S), .AWSIZE_S(AWSIZE_S),
    .AWBURST_S(AWBURST_S), .AWVALID_S(AWVALID_S), .AWREADY_S(AWREADY_S),
    .WDATA_S(WDATA_S), .WSTRB_S(WSTRB_S), .WLAST_S(WLAST_S), .WVALID_S(WVALID_S),
    .WREADY_S(WREADY_S), .BID_S(BID_S), .BRESP_S(BRESP_S), .BVALID_S(BVALID_S),
    .BREADY_S(BREADY_S), .wlast_err(wlast_err)
  );

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  // Per-master response-side outputs packed as {awready, wready, bvalid, bid, bresp}
  logic [8:0] out_m [2];
  assign out_m[0] = {AWREADY_M0, WREADY_M0, BVALID_M0, BID_M0, BRESP_M0};
  assign out_m[1] = {AWREADY_M1, WREADY_M1, BVALID_M1, BID_M1, BRESP_M1};

  int n_assert = 0;
  int n_fail   = 0;

  // Reference-model state and per-master transaction parameters
  int             last_grant_m;
  logic [IDB-1:0] id_m    [2];
  logic [AB-1:0]  addr_m  [2];
  logic [LB-1:0]  len_m   [2];
  logic [2:0]     size_m  [2];
  logic [1:0]     burst_m [2];
  logic [1:0]     resp_val;
  logic           tgl;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic set_aw(input int m, input logic v);
    if (m == 0) begin
      AWVALID_M0 = v; AWID_M0 = id_m[0]; AWADDR_M0 = addr_m[0]; AWLEN_M0 = len_m[0];
      AWSIZE_M0 = size_m[0]; AWBURST_M0 = burst_m[0];
    end else begin
      AWVALID_M1 = v; AWID_M1 = id_m[1]; AWADDR_M1 = addr_m[1]; AWLEN_M1 = len_m[1];
      AWSIZE_M1 = size_m[1]; AWBURST_M1 = burst_m[1];
    end
  endtask

  task automatic set_w(input int m, input logic v, input logic [DB-1:0] d,
                       input logic [DB/8-1:0] s, input logic l);
    if (m == 0) begin
      WVALID_M0 = v; WDATA_M0 = d; WSTRB_M0 = s; WLAST_M0 = l;
    end else begin
      WVALID_M1 = v; WDATA_M1 = d; WSTRB_M1 = s; WLAST_M1 = l;
    end
  endtask

  task automatic set_bready(input int m, input logic v);
    if (m == 0) BREADY_M0 = v;
    else        BREADY_M1 = v;
  endtask

  task automatic chk_all_idle(input string tag);
    chk(tag, {AWVALID_S, WVALID_S, BREADY_S, AWREADY_M0, AWREADY_M1, WREADY_M0, WREADY_M1,
              BVALID_M0, BVALID_M1, wlast_err}, 64'd0);
  endtask

  // One full write transaction. wl_beat: beat index on which the master raises WLAST (-1 = last).
  // rmode: 0 WREADY_S always 1, 1 random, 2 alternating. abort_after: stop in DATA before that beat.
  task automatic run_txn(input bit v0, input bit v1, input bit keep, input int wl_beat,
                         input int rmode, input int abort_after);
    int g, o, n, len;
    logic [DB-1:0] dat;
    logic [DB/8-1:0] stb;
    logic hs, bv;
    g   = (v0 && v1) ? 1 - last_grant_m : (v0 ? 0 : 1);
    o   = 1 - g;
    len = int'(len_m[g]);
    if (wl_beat < 0) wl_beat = len;
    set_aw(0, v0);
    set_aw(1, v1);
    AWREADY_S = 1'b0; WREADY_S = 1'b0; BVALID_S = 1'b0;
    // Idle cycle: request seen, nothing forwarded yet
    @(negedge ACLK);
    chk_all_idle("idle_outputs");
    tick();
    // Address phase
    n = 0;
    do begin
      AWREADY_S = (n >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
      @(negedge ACLK);
      chk("awvalid_s", AWVALID_S, 1);
      chk("awid_s", AWID_S, {4'(g), id_m[g]});
      chk("aw_fields", {AWADDR_S, AWLEN_S, AWSIZE_S, AWBURST_S},
          {addr_m[g], len_m[g], size_m[g], burst_m[g]});
      chk("addr_granted_out", out_m[g], {AWREADY_S, 8'd0});
      chk("addr_other_out", out_m[o], 0);
      chk("addr_no_w", {WVALID_S, BREADY_S, wlast_err}, 0);
      hs = AWREADY_S;
      n++;
      tick();
    end while (!hs);
    AWREADY_S = 1'b0;
    if (!keep) set_aw(g, 1'b0);
    // The other master offers junk W data that must never reach the slave
    set_w(o, 1'b1, DB'($urandom), '1, 1'b1);
    // Data phase
    for (int b = 0; b <= len; b++) begin
      if (b == abort_after) return;
      dat = DB'($urandom);
      stb = (DB/8)'($urandom);
      set_w(g, 1'b1, dat, stb, 1'(b == wl_beat));
      n = 0;
      do begin
        case (rmode)
          0:       WREADY_S = 1'b1;
          1:       WREADY_S = (n >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
          default: begin WREADY_S = tgl; tgl = ~tgl; end
        endcase
        BVALID_S = 1'($urandom_range(0, 1));
        BID_S    = 8'($urandom);
        BRESP_S  = 2'($urandom);
        @(negedge ACLK);
        chk("wvalid_s", WVALID_S, 1);
        chk("wdata_s", {WDATA_S, WSTRB_S}, {dat, stb});
        chk("wlast_s", WLAST_S, (b == len));
        chk("wlast_err", wlast_err, WREADY_S && ((b == wl_beat) != (b == len)));
        chk("data_granted_out", out_m[g], {1'b0, WREADY_S, 7'd0});
        chk("data_other_out", out_m[o], 0);
        chk("data_no_aw_b", {AWVALID_S, BREADY_S}, 0);
        hs = WREADY_S;
        n++;
        tick();
      end while (!hs);
    end
    set_w(g, 1'b0, '0, '0, 1'b0);
    set_w(o, 1'b0, '0, '0, 1'b0);
    WREADY_S = 1'b0;
    // Response phase
    n = 0;
    do begin
      bv       = (n >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
      BVALID_S = bv;
      BID_S    = {4'(g), id_m[g]};
      BRESP_S  = resp_val;
      set_bready(g, (n >= 2) ? 1'b1 : 1'($urandom_range(0, 1)));
      set_bready(o, 1'b1);
      @(negedge ACLK);
      hs = bv && ((g == 0) ? BREADY_M0 : BREADY_M1);
      chk("bready_s", BREADY_S, (g == 0) ? BREADY_M0 : BREADY_M1);
      chk("resp_granted_out", out_m[g],
          {2'b00, bv, bv ? id_m[g] : 4'd0, bv ? resp_val : 2'd0});
      chk("resp_other_out", out_m[o], 0);
      chk("resp_no_aw_w", {AWVALID_S, WVALID_S, wlast_err}, 0);
      n++;
      tick();
    end while (!hs);
    last_grant_m = g;
    BVALID_S = 1'b0;
    set_bready(0, 1'b0);
    set_bready(1, 1'b0);
  endtask

  task automatic rand_params(input int m);
    id_m[m]    = 4'($urandom);
    addr_m[m]  = AB'($urandom);
    len_m[m]   = 4'($urandom);
    size_m[m]  = 3'($urandom);
    burst_m[m] = 2'($urandom);
  endtask

  initial begin
    int v;
    int wl;
    ARESETn = 1'b0;
    AWVALID_M0 = 0; AWID_M0 = 0; AWADDR_M0 = 0; AWLEN_M0 = 0; AWSIZE_M0 = 0; AWBURST_M0 = 0;
    AWVALID_M1 = 0; AWID_M1 = 0; AWADDR_M1 = 0; AWLEN_M1 = 0; AWSIZE_M1 = 0; AWBURST_M1 = 0;
    WVALID_M0 = 0; WDATA_M0 = 0; WSTRB_M0 = 0; WLAST_M0 = 0; BREADY_M0 = 0;
    WVALID_M1 = 0; WDATA_M1 = 0; WSTRB_M1 = 0; WLAST_M1 = 0; BREADY_M1 = 0;
    AWREADY_S = 0; WREADY_S = 0; BVALID_S = 0; BID_S = 0; BRESP_S = 0;
    tgl = 1'b1;
    resp_val = 2'd0;
    last_grant_m = 1;
    for (int m = 0; m < 2; m++) rand_params(m);

    // Reset state
    repeat (2) @(posedge ACLK);
    @(negedge ACLK);
    chk_all_idle("reset_outputs");
    chk("reset_data", {AWID_S, AWADDR_S, WDATA_S, WLAST_S, out_m[0], out_m[1]}, 0);
    ARESETn = 1'b1;
    tick();

    // Contention: both held valid, single-beat bursts, expected order M0, M1, M0
    for (int i = 0; i < 3; i++) begin
      for (int m = 0; m < 2; m++) begin
        rand_params(m);
        len_m[m] = 4'd0;
      end
      resp_val = 2'($urandom);
      run_txn(1'b1, 1'b1, 1'b1, -1, 0, -1);
    end
    set_aw(0, 1'b0);
    set_aw(1, 1'b0);

    // Single M0 write
    id_m[0] = 4'd3; addr_m[0] = 32'h1000; len_m[0] = 4'd3; size_m[0] = 3'd2; burst_m[0] = 2'd1;
    resp_val = 2'd0;
    run_txn(1'b1, 1'b0, 1'b0, -1, 0, -1);

    // Backpressure on a 2-beat M1 burst
    rand_params(1);
    len_m[1] = 4'd1;
    tgl = 1'b1;
    run_txn(1'b0, 1'b1, 1'b0, -1, 2, -1);

    // WLAST mismatch: M0 raises WLAST on the first of three beats
    rand_params(0);
    len_m[0] = 4'd2;
    run_txn(1'b1, 1'b0, 1'b0, 0, 0, -1);

    // Full-length burst
    rand_params(1);
    len_m[1] = 4'd15;
    run_txn(1'b0, 1'b1, 1'b0, -1, 1, -1);

    // Randomized traffic
    for (int i = 0; i < 20; i++) begin
      v = $urandom_range(1, 3);
      for (int m = 0; m < 2; m++) rand_params(m);
      resp_val = 2'($urandom);
      wl = -1;
      if ($urandom_range(0, 3) == 0) wl = $urandom_range(0, 15);
      run_txn(1'(v), 1'(v >> 1), 1'b0, wl, 1, -1);
      set_aw(0, 1'b0);
      set_aw(1, 1'b0);
    end

    // Reset mid-DATA: one beat of a 4-beat M0 burst accepted, then reset
    rand_params(0);
    len_m[0] = 4'd3;
    run_txn(1'b1, 1'b0, 1'b0, -1, 0, 1);
    set_w(0, 1'b1, 32'hdead_beef, 4'hf, 1'b0);
    WREADY_S = 1'b1;
    #1;
    chk("pre_reset_wvalid", WVALID_S, 1);
    ARESETn = 1'b0;
    #1;
    chk_all_idle("async_reset_outputs");
    chk("async_reset_data", {WDATA_S, WLAST_S, AWID_S}, 0);
    set_w(0, 1'b0, '0, '0, 1'b0);
    WREADY_S = 1'b0;
    repeat (2) @(posedge ACLK);
    @(negedge ACLK);
    ARESETn = 1'b1;
    last_grant_m = 1;
    tick();

    // After reset: M1 alone is granted, then contention goes to M0
    rand_params(1);
    len_m[1] = 4'd2;
    run_txn(1'b0, 1'b1, 1'b0, -1, 1, -1);
    for (int m = 0; m < 2; m++) begin
      rand_params(m);
      len_m[m] = 4'd1;
    end
    run_txn(1'b1, 1'b1, 1'b0, -1, 1, -1);
    set_aw(0, 1'b0);
    set_aw(1, 1'b0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
